cv32e40x_bch_pred_ctrl: RTL and testbench

Dynamic branch-prediction controller for the ID/EX pair. It looks up a per-PC 2-bit saturating counter table to predict conditional branches in ID, with the static backward-taken rule as fallback for untrained entries. It tracks the one prediction in flight to EX and flags mispredictions at resolution so the controller can redirect to the branch target or to the fall-through PC. It then trains the table and counts mispredictions.

---
 rtl/cv32e40x_bch_pred_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cv32e40x_bch_pred_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_bch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40x_bch_pred_ctrl
//
// Dynamic branch-prediction controller for the ID/EX stage pair.
//
// A table of per-PC 2-bit saturating counters predicts conditional branches in
// ID. Entries that have never been trained fall back to the static rule:
// backward branches (negative immediate) are predicted taken. The single
// prediction travelling from ID to EX is held in a pending register. When the
// branch resolves in EX, a misprediction is flagged combinationally together
// with the redirect direction. The table entry is then trained and a
// saturating misprediction counter is incremented.
//
// Parameters
//   BHT_DEPTH           number of table entries (power of two, 2..256)
//
// Ports
//   clk                 clock, all state updates on the rising edge
//   rst                 asynchronous active-high reset
//   id_bch_valid_i      conditional branch present in ID
//   id_ready_i          ID instruction advances to EX this cycle
//   pc_id_i             PC of the ID instruction
//   imm_sb_type_i       branch immediate; bit 31 drives the static fallback
//   bch_prediction_id_o predict taken for the ID branch (combinational)
//   ex_bch_valid_i      branch in EX resolves this cycle
//   ex_bch_taken_i      resolved outcome, qualified by ex_bch_valid_i
//   kill_i              pipeline flush of ID and EX
//   mispredict_o        resolving branch was mispredicted (combinational)
//   mispredict_taken_o  with mispredict_o: 1 = redirect to target,
//                       0 = redirect to fall-through
//   mispred_cnt_o       saturating misprediction count
// -----------------------------------------------------------------------------
module cv32e40x_bch_pred_ctrl #(
  parameter int unsigned BHT_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_bch_valid_i,
  input  logic        id_ready_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] imm_sb_type_i,
  output logic        bch_prediction_id_o,
  input  logic        ex_bch_valid_i,
  input  logic        ex_bch_taken_i,
  input  logic        kill_i,
  output logic        mispredict_o,
  output logic        mispredict_taken_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  localparam logic [1:0]  CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0]  CTR_MAX   = 2'b11;
  localparam logic [1:0]  CTR_MIN   = 2'b00;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [BHT_DEPTH-1:0] bht_valid_q;
  logic [1:0]           bht_ctr_q [BHT_DEPTH];

  logic                 pend_valid_q;
  logic                 pend_pred_q;
  logic [IDX_W-1:0]     pend_idx_q;

  logic [31:0]          mispred_cnt_q;

  // ---------------------------------------------------------------------------
  // Decoded events
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_valid;
  logic [1:0]       lookup_ctr;
  logic             prediction;

  logic             resolve;      // R: pending branch resolves in EX
  logic             capture;      // C: ID branch moves into EX
  logic             mispredict;

  logic             train_valid;  // pre-update state of the entry being trained
  logic [1:0]       train_ctr;
  logic [1:0]       train_ctr_nxt;

  logic             cnt_inc;

  // Only the index bits of the PC and the sign bit of the immediate are used.
  logic unused_inputs;
  assign unused_inputs = ^{pc_id_i[31:IDX_W+1], pc_id_i[0], imm_sb_type_i[30:0]};

  // ---------------------------------------------------------------------------
  // Lookup in ID
  // ---------------------------------------------------------------------------
  // PC bit 0 is always zero for branch targets, so the index starts at bit 1.
  assign lookup_idx   = pc_id_i[IDX_W:1];
  assign lookup_valid = bht_valid_q[lookup_idx];
  assign lookup_ctr   = bht_ctr_q[lookup_idx];

  // The lookup sees the table as it was before this edge; a training update
  // happening in the same cycle is deliberately not bypassed.
  assign prediction = id_bch_valid_i &
                      (lookup_valid ? lookup_ctr[1] : imm_sb_type_i[31]);

  assign bch_prediction_id_o = prediction;

  // ---------------------------------------------------------------------------
  // Resolution in EX
  // ---------------------------------------------------------------------------
  // A resolving branch without a pending prediction is ignored altogether.
  assign resolve    = ex_bch_valid_i & pend_valid_q & ~kill_i;
  assign capture    = id_bch_valid_i & id_ready_i;
  assign mispredict = resolve & (pend_pred_q != ex_bch_taken_i);

  assign mispredict_o       = mispredict;
  assign mispredict_taken_o = mispredict & ex_bch_taken_i;

  // ---------------------------------------------------------------------------
  // Training value for the pending entry
  // ---------------------------------------------------------------------------
  assign train_valid = bht_valid_q[pend_idx_q];
  assign train_ctr   = bht_ctr_q[pend_idx_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    train_ctr_nxt = train_ctr;
    if (!train_valid) begin
      // First observation seeds the counter in the weak state of the outcome.
      train_ctr_nxt = ex_bch_taken_i ? 2'b10 : 2'b01;
    end else if (ex_bch_taken_i) begin
      if (train_ctr != CTR_MAX) begin
        train_ctr_nxt = train_ctr + 2'b01;
      end
    end else begin
      if (train_ctr != CTR_MIN) begin
        train_ctr_nxt = train_ctr - 2'b01;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
  // NOTE: the table is a register array with a reset, not a RAM; an untrained
  // entry must read as invalid from the first cycle after reset, so every entry
  // is cleared explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // always_ff sees pre-edge values regardless of evaluation order.
      bht_valid_q <= '0;
      for (int i = 0; i < int'(BHT_DEPTH); i++) begin
        bht_ctr_q[i] <= CTR_RESET;
      end
    end else if (resolve) begin
      bht_valid_q[pend_idx_q] <= 1'b1;
      bht_ctr_q[pend_idx_q]   <= train_ctr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending prediction register
  // ---------------------------------------------------------------------------
  // A capture in the same cycle as a resolve trains with the old index (above)
  // and loads the new one here. kill_i wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_pred_q  <= 1'b0;
      pend_idx_q   <= '0;
    end else if (kill_i) begin
      pend_valid_q <= 1'b0;
    end else if (capture) begin
      pend_valid_q <= 1'b1;
      pend_pred_q  <= prediction;
      pend_idx_q   <= lookup_idx;
    end else if (resolve) begin
      pend_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Misprediction counter, saturating at all-ones
  // ---------------------------------------------------------------------------
  assign cnt_inc = mispredict & (mispred_cnt_q != CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_cnt_q <= '0;
    end else if (cnt_inc) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_cv32e40x_bch_pred_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cv32e40x_bch_pred_ctrl
//
// Self-checking bench for cv32e40x_bch_pred_ctrl (BHT_DEPTH = 16). A behavioural
// model of the table, pending register and counter runs alongside the DUT;
// expected outputs are pushed to a scoreboard queue as each cycle is driven and
// popped when the DUT outputs are sampled. Directed checks pin down the
// documented scenarios, followed by a randomised phase.
// -----------------------------------------------------------------------------
module tb_cv32e40x_bch_pred_ctrl;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_bch_valid;
  logic        id_ready;
  logic [31:0] pc_id;
  logic [31:0] imm_sb_type;
  logic        bch_prediction_id;
  logic        ex_bch_valid;
  logic        ex_bch_taken;
  logic        kill;
  logic        mispredict;
  logic        mispredict_taken;
  logic [31:0] mispred_cnt;

  cv32e40x_bch_pred_ctrl #(.BHT_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_bch_valid_i      (id_bch_valid),
    .id_ready_i          (id_ready),
    .pc_id_i             (pc_id),
    .imm_sb_type_i       (imm_sb_type),
    .bch_prediction_id_o (bch_prediction_id),
    .ex_bch_valid_i      (ex_bch_valid),
    .ex_bch_taken_i      (ex_bch_taken),
    .kill_i              (kill),
    .mispredict_o        (mispredict),
    .mispredict_taken_o  (mispredict_taken),
    .mispred_cnt_o       (mispred_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] IMM_NEG = 32'hFFFF_FFF0;
  localparam logic [31:0] IMM_POS = 32'h0000_0010;

  // Reference model state
  logic        m_valid [DEPTH];
  logic [1:0]  m_ctr   [DEPTH];
  logic        m_pv;
  logic        m_pp;
  logic [3:0]  m_pi;
  logic [31:0] m_cnt;

  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Last sampled combinational outputs
  logic obs_pred, obs_mis, obs_mt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'b01;
    end
    m_pv  = 1'b0;
    m_pp  = 1'b0;
    m_pi  = '0;
    m_cnt = '0;
  endtask

  // One clock cycle: drive after the falling edge, sample combinational outputs
  // before the rising edge, advance the model on the edge, then check the count.
  task automatic step(input logic idv, input logic rdy, input logic [31:0] pc,
                      input logic [31:0] imm, input logic exv, input logic ext,
                      input logic kl);
    logic [3:0] li;
    logic       ep, r, em;
    @(negedge clk);
    id_bch_valid = idv;
    id_ready     = rdy;
    pc_id        = pc;
    imm_sb_type  = imm;
    ex_bch_valid = exv;
    ex_bch_taken = ext;
    kill         = kl;

    li = pc[4:1];
    ep = idv & (m_valid[li] ? m_ctr[li][1] : imm[31]);
    r  = exv & m_pv & ~kl;
    em = r & (m_pp != ext);
    exp_q.push_back({31'd0, ep});
    exp_q.push_back({31'd0, em});
    exp_q.push_back({31'd0, em & ext});

    #1;
    obs_pred = bch_prediction_id;
    obs_mis  = mispredict;
    obs_mt   = mispredict_taken;
    check("pred",   {31'd0, obs_pred}, exp_q.pop_front());
    check("mis",    {31'd0, obs_mis},  exp_q.pop_front());
    check("mis_tk", {31'd0, obs_mt},   exp_q.pop_front());

    @(posedge clk);
    if (kl) begin
      m_pv = 1'b0;
    end else begin
      if (r) begin
        if (!m_valid[m_pi]) begin
          m_valid[m_pi] = 1'b1;
          m_ctr[m_pi]   = ext ? 2'b10 : 2'b01;
        end else if (ext) begin
          if (m_ctr[m_pi] != 2'b11) m_ctr[m_pi] = m_ctr[m_pi] + 2'b01;
        end else begin
          if (m_ctr[m_pi] != 2'b00) m_ctr[m_pi] = m_ctr[m_pi] - 2'b01;
        end
        if (em && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (idv && rdy) begin
        m_pv = 1'b1;
        m_pp = ep;
        m_pi = li;
      end else if (r) begin
        m_pv = 1'b0;
      end
    end
    #1;
    check("cnt", mispred_cnt, m_cnt);
  endtask

  initial begin
    model_reset();
    rst          = 1'b1;
    id_bch_valid = 1'b1;
    id_ready     = 1'b0;
    pc_id        = 32'h100;
    imm_sb_type  = IMM_NEG;
    ex_bch_valid = 1'b0;
    ex_bch_taken = 1'b0;
    kill         = 1'b0;

    // Reset values
    #3;
    check("rst_pred",   {31'd0, bch_prediction_id}, 32'd1);
    check("rst_mis",    {31'd0, mispredict},        32'd0);
    check("rst_mis_tk", {31'd0, mispredict_taken},  32'd0);
    check("rst_cnt",    mispred_cnt,                32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Static fallback on an untrained entry
    step(1, 0, 32'h100, IMM_NEG, 0, 0, 0);
    check("static_neg", {31'd0, obs_pred}, 32'd1);
    step(1, 0, 32'h100, IMM_POS, 0, 0, 0);
    check("static_pos", {31'd0, obs_pred}, 32'd0);

    // Capture predicted taken, resolve not taken
    step(1, 1, 32'h100, IMM_NEG, 0, 0, 0);
    step(0, 0, 32'h0,   32'h0,   1, 0, 0);
    check("first_mis",    {31'd0, obs_mis}, 32'd1);
    check("first_mis_tk", {31'd0, obs_mt},  32'd0);
    check("first_cnt",    mispred_cnt,      32'd1);
    step(1, 0, 32'h100, IMM_NEG, 0, 0, 0);
    check("trained_nt", {31'd0, obs_pred}, 32'd0);

    // Saturate entry 2 upward, then walk it back down
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 32'h104, IMM_POS, 0, 0, 0);
      step(0, 0, 32'h0,   32'h0,   1, 1, 0);
    end
    step(1, 0, 32'h104, IMM_POS, 0, 0, 0);
    check("sat_hi_pred", {31'd0, obs_pred}, 32'd1);
    step(1, 1, 32'h104, IMM_POS, 0, 0, 0);
    step(0, 0, 32'h0,   32'h0,   1, 0, 0);
    step(1, 0, 32'h104, IMM_POS, 0, 0, 0);
    check("nt1_pred", {31'd0, obs_pred}, 32'd1);
    step(1, 1, 32'h104, IMM_POS, 0, 0, 0);
    step(0, 0, 32'h0,   32'h0,   1, 0, 0);
    step(1, 0, 32'h104, IMM_POS, 0, 0, 0);
    check("nt2_pred", {31'd0, obs_pred}, 32'd0);

    // Kill with a mispredicting resolve and a capture attempt
    step(1, 1, 32'h100, IMM_NEG, 0, 0, 0);
    step(1, 1, 32'h106, IMM_POS, 1, 1, 1);
    check("kill_mis", {31'd0, obs_mis}, 32'd0);
    step(0, 0, 32'h0,   32'h0,   1, 1, 0);
    check("kill_nopend", {31'd0, obs_mis}, 32'd0);

    // Same-cycle resolve and capture on index 3
    step(1, 1, 32'h106, IMM_POS, 0, 0, 0);
    step(0, 0, 32'h0,   32'h0,   1, 0, 0);
    step(1, 1, 32'h106, IMM_POS, 0, 0, 0);
    step(1, 1, 32'h106, IMM_POS, 1, 1, 0);
    check("rc_mis",  {31'd0, obs_mis},  32'd1);
    check("rc_pred", {31'd0, obs_pred}, 32'd0);
    step(0, 0, 32'h0,   32'h0,   1, 1, 0);
    check("rc_next_mis", {31'd0, obs_mis}, 32'd1);

    // Counter saturation
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    check("cnt_preload", mispred_cnt, 32'hFFFF_FFFE);
    step(1, 1, 32'h100, IMM_NEG, 0, 0, 0);
    step(0, 0, 32'h0,   32'h0,   1, 1, 0);
    check("cnt_max", mispred_cnt, 32'hFFFF_FFFF);
    step(1, 1, 32'h100, IMM_NEG, 0, 0, 0);
    step(0, 0, 32'h0,   32'h0,   1, 0, 0);
    check("cnt_hold", {31'd0, obs_mis}, 32'd1);
    check("cnt_sat",  mispred_cnt,      32'hFFFF_FFFF);

    // Randomised traffic over a few overlapping indices
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'h100 + 32'($urandom_range(0, 7) << 1),
           $urandom_range(0, 1) ? IMM_NEG : IMM_POS,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0);
    end

    // Reset asserted in the middle of a mispredicting resolve
    step(1, 1, 32'h104, IMM_NEG, 0, 0, 0);
    @(negedge clk);
    id_bch_valid = 1'b1;
    id_ready     = 1'b0;
    pc_id        = 32'h104;
    imm_sb_type  = IMM_NEG;
    ex_bch_valid = 1'b1;
    ex_bch_taken = ~m_pp;
    kill         = 1'b0;
    #1;
    check("pre_rst_mis", {31'd0, mispredict}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_mis",    {31'd0, mispredict},        32'd0);
    check("arst_mis_tk", {31'd0, mispredict_taken},  32'd0);
    check("arst_cnt",    mispred_cnt,                32'd0);
    check("arst_pred",   {31'd0, bch_prediction_id}, 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 32'h104, IMM_NEG, 0, 0, 0);
    check("post_rst_pred", {31'd0, obs_pred}, 32'd1);
    step(0, 0, 32'h0, 32'h0, 1, 1, 0);
    check("post_rst_nopend", {31'd0, obs_mis}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
